fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the register-file/ALU datapath block.
- Owns the program counter and drives a synchronous instruction memory with 1-cycle read latency.
- Presents each fetched instruction with its PC and decoded rs1/rs2/rd fields under a valid/ready handshake.
- Accepts branch redirects from control (PCsrc path) and supports halt/resume.

Parameters:
A_WIDTH, 32, PC / instruction-memory address width
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0

Ports:
clk  input  1  main clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
imem_addr  output  A_WIDTH  address to instruction memory; sampled by memory at each rising edge
imem_rdata  input  32  memory data for the address sampled at the previous edge
valid_out  output  1  instr/pc_out/fields hold a valid instruction
ready_in  input  1  downstream consumes the instruction this cycle when valid_out=1
instr  output  32  current instruction, driven combinationally from imem_rdata
pc_out  output  A_WIDTH  address of instr
rs1  output  5  instr[19:15]
rs2  output  5  instr[24:20]
rd  output  5  instr[11:7]
branch_taken  input  1  redirect request (PCsrc) for the instruction currently presented
branch_target  input  A_WIDTH  redirect address (PC+ImmOp); bits [1:0] are forced to 0 internally
halt  input  1  stop fetching after the current handshake
retire_cnt  output  32  count of accepted instructions (valid_out && ready_in); wraps at 2^32

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=FILL, pc_q=RESET_PC, valid_out=0, retire_cnt=0, imem_addr=RESET_PC.
- Reset mid-operation takes effect immediately. Any in-flight instruction is discarded.
- Derived signals: accept = valid_out && ready_in. valid_out = (state==RUN).
- pc_out = pc_q. Decoded fields are slices of instr.
- States and transitions:
  - FILL: imem_addr=pc_q. Next edge: state -> RUN (-> HALT if halt=1). pc_q held. Exactly one bubble.
  - RUN, accept && branch_taken: imem_addr={branch_target[A_WIDTH-1:2],2'b00}. pc_q <= that value. Target is presented the next cycle with zero bubble.
  - RUN, accept && !branch_taken: imem_addr=pc_q+4. pc_q <= pc_q+4, modulo 2^A_WIDTH, so 0xFFFF_FFFC wraps to 0.
  - RUN, !accept (stall): imem_addr=pc_q. Memory re-reads the same word, so instr, pc_out and fields stay stable. branch_taken is ignored.
  - RUN, halt=1: state <= HALT at the next edge. The pc_q update still follows the accept/branch rules of that cycle.
  - HALT: valid_out=0, imem_addr=pc_q, pc_q held, branch_taken ignored. When halt=0: state <= FILL.
- retire_cnt increments by 1 on each edge where accept=1, independent of branch or halt.
- A branch accepted with halt=1 in the same cycle loads the target into pc_q first. Resume then fetches the target.
- Simultaneous halt=1 in FILL: FILL -> HALT, no instruction presented.

Decomposition:
- Package fetch_pkg holds:
  - enum fetch_state_t {FILL, RUN, HALT}
  - INSTR_W=32
  - field position constants RS1_LSB=15, RS2_LSB=20, RD_LSB=7, FIELD_W=5
  - PC_STEP=4
- One sub-module is natural: pc_next_sel, purely combinational. It selects the next pc and imem_addr from state, accept, branch_taken, branch_target and pc_q.
- The top level holds the state register, pc_q, retire_cnt and field extraction.

Test Plan:
- Reset release, ready_in=1, memory word at addr 4k holds value k: valid_out=0 for one cycle. Then pc_out=0,4,8,... on consecutive cycles, instr=0,1,2. retire_cnt=3 after three accepts.
- Stall: ready_in=0 for 3 cycles while pc_out=8. instr, pc_out and rs1/rs2/rd hold for all 3 cycles, retire_cnt is unchanged. pc_out=12 on the cycle after ready_in returns to 1.
- Branch: at pc_out=8 assert branch_taken with branch_target=0x40, ready_in=1. Next cycle pc_out=0x40, valid_out=1, no bubble. branch_target=0x43 gives pc_out=0x40.
- Branch during stall: branch_taken=1, ready_in=0 at pc_out=8. Ignored; pc_out stays 8.
- Halt/resume: halt=1 for one accept at pc_out=0x10, then held 4 cycles. valid_out=0 while halted. After halt=0 there is one FILL bubble, then pc_out=0x14.
- Async reset mid-run at pc_out=0x20, asserted between edges: valid_out=0 and imem_addr=0 immediately, retire_cnt=0. After release, the sequence restarts as in scenario 1.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {FILL, RUN, HALT} fetch_state_t;
  localparam int INSTR_W = 32;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;
  localparam int FIELD_W = 5;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, downstream handshake and control signals of the fetch stage
interface fetch_stage_if #(parameter int A_WIDTH = 32);
  import fetch_pkg::*;
  logic [A_WIDTH-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               valid_out;
  logic               ready_in;
  logic [INSTR_W-1:0] instr;
  logic [A_WIDTH-1:0] pc_out;
  logic [FIELD_W-1:0] rs1;
  logic [FIELD_W-1:0] rs2;
  logic [FIELD_W-1:0] rd;
  logic               branch_taken;
  logic [A_WIDTH-1:0] branch_target;
  logic               halt;
  modport master (
    output imem_addr, valid_out, instr, pc_out, rs1, rs2, rd,
    input  imem_rdata, ready_in, branch_taken, branch_target, halt
  );
  modport slave (
    input  imem_addr, valid_out, instr, pc_out, rs1, rs2, rd,
    output imem_rdata, ready_in, branch_taken, branch_target, halt
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-pc / fetch-address selection (sequential, branch redirect or hold)
module pc_next_sel import fetch_pkg::*; #(
  parameter int A_WIDTH = 32
) (
  input  fetch_state_t       state,
  input  logic               accept,
  input  logic               branch_taken,
  input  logic [A_WIDTH-1:0] branch_target,
  input  logic [A_WIDTH-1:0] pc_q,
  output logic [A_WIDTH-1:0] pc_next
);
  always_comb
    pc_next = (state == RUN && accept)
            ? (branch_taken ? (branch_target & ~A_WIDTH'(3)) : pc_q + A_WIDTH'(PC_STEP))
            : pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: pc register, fill/run/halt control and instruction presentation with valid/ready
module fetch_stage import fetch_pkg::*; #(
  parameter int                 A_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        bus,
  output logic [31:0]          retire_cnt
);
  fetch_state_t       state, state_next;
  logic [A_WIDTH-1:0] pc_q, pc_next;
  logic               accept;
  assign bus.valid_out = (state == RUN);
  assign accept        = bus.valid_out && bus.ready_in;
  pc_next_sel #(.A_WIDTH(A_WIDTH)) u_sel (
    .state(state),
    .accept(accept),
    .branch_taken(bus.branch_taken),
    .branch_target(bus.branch_target),
    .pc_q(pc_q),
    .pc_next(pc_next)
  );
  // memory is addressed with the next pc so a stall re-reads the same word
  assign bus.imem_addr = pc_next;
  assign bus.instr     = bus.imem_rdata;
  assign bus.pc_out    = pc_q;
  assign bus.rs1       = bus.instr[RS1_LSB +: FIELD_W];
  assign bus.rs2       = bus.instr[RS2_LSB +: FIELD_W];
  assign bus.rd        = bus.instr[RD_LSB +: FIELD_W];
  always_comb
    state_next = bus.halt ? HALT : (state == HALT ? FILL : RUN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= FILL;
      pc_q       <= RESET_PC;
      retire_cnt <= '0;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      if (accept) retire_cnt <= retire_cnt + 32'd1;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage with a 1-cycle synchronous memory model
module tb_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        pat;
  logic [31:0] retire_cnt;
  logic [31:0] exp_ret;
  logic [31:0] sb[$];
  int          n_assert;
  int          n_fail;

  fetch_stage_if #(.A_WIDTH(32)) bus ();

  fetch_stage #(.A_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word at address 4k holds k; with pat set, k is also spread into rd/rs1/rs2
  function automatic logic [31:0] memw(input logic [31:0] a);
    logic [31:0] k;
    k = {2'b00, a[31:2]};
    return pat ? k * 32'h0010_8081 : k;
  endfunction

  always @(posedge clk) bus.imem_rdata <= memw(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic br, input logic [31:0] tgt,
                      input logic h, input logic ev);
    logic [31:0] e, w;
    bus.ready_in      = r;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.halt          = h;
    @(negedge clk);
    chk("valid", {31'b0, bus.valid_out}, {31'b0, ev});
    chk("retire", retire_cnt, exp_ret);
    if (ev) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL sb_empty: observed pc %h expected none", bus.pc_out);
      end else begin
        e = sb[0];
        w = memw(e);
        chk("pc", bus.pc_out, e);
        chk("instr", bus.instr, w);
        chk("rs1", {27'b0, bus.rs1}, {27'b0, w[19:15]});
        chk("rs2", {27'b0, bus.rs2}, {27'b0, w[24:20]});
        chk("rd", {27'b0, bus.rd}, {27'b0, w[11:7]});
        if (r) begin
          void'(sb.pop_front());
          exp_ret++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_ret  = 0;
    pat      = 1'b0;
    rst_n    = 1'b0;
    bus.ready_in      = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.halt          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    rst_n = 1'b1;
    // fill bubble, sequential fetch, stall with an ignored branch
    step(1, 0, 0, 0, 0);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    repeat (3) step(0, 1, 32'h80, 0, 1);
    step(1, 0, 0, 0, 1);
    // branch redirects, target low bits forced to zero
    sb.push_back(32'h40); sb.push_back(32'h40); sb.push_back(32'h10);
    step(1, 1, 32'h40, 0, 1);
    step(1, 1, 32'h43, 0, 1);
    step(1, 1, 32'h10, 0, 1);
    // halt on accept at 0x10, hold, resume with one fill bubble
    sb.push_back(32'h14); sb.push_back(32'h18); sb.push_back(32'h1C); sb.push_back(32'h20);
    step(1, 0, 0, 1, 1);
    step(1, 1, 32'h100, 1, 0);
    repeat (3) step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // asynchronous reset between edges while 0x20 is presented
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("arst_addr", bus.imem_addr, 32'd0);
    chk("arst_cnt", retire_cnt, 32'd0);
    sb.delete();
    exp_ret = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, 0, 0, 0);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
    repeat (3) step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // halt during fill, then field decode and pc wrap with spread pattern
    rst_n    = 1'b0;
    pat      = 1'b1;
    bus.halt = 1'b1;
    sb.delete();
    exp_ret = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    sb.push_back(32'h0); sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0); sb.push_back(32'h4);
    step(1, 1, 32'hFFFF_FFFF, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
